left_norm_shifter_seq: RTL
==========================

// Module: left_norm_shifter_seq
// PURPOSE
//  Iterative left-normalization shifter for the Add-Subt datapath, mirror of the right-shift alignment array.
//  Accepts an unnormalized significand and removes leading zeros one binary-search level per cycle
//  (largest level first).
//  Shifts toward the MSB with zero fill at the LSB.
//  Returns the normalized word, the shift count for exponent correction, and a zero flag.
//  Sits between the significand adder and the rounding/exponent-update stage.
// PARAMETERS
//  SWR     26                  significand width in bits, >= 2
//  LEVELS  $clog2(SWR) (=5)    localparam; number of shift levels; SW = LEVELS bits
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  in_valid_i   in   1      Data_i valid
//  in_ready_o   out  1      block can accept; high only in IDLE
//  Data_i       in   SWR    unnormalized significand
//  out_valid_o  out  1      result valid; high only in DONE
//  out_ready_i  in   1      consumer accepts result
//  Data_o       out  SWR    normalized significand (MSB=1 unless Zero_o)
//  Shift_o      out  LEVELS total left-shift applied (= leading-zero count)
//  Zero_o       out  1      Data_i was all zeros
// BEHAVIOUR
//  Reset (async, any state):
//   - state=IDLE; in_ready_o=1; out_valid_o=0; Data_o=0; Shift_o=0; Zero_o=0.
//   - An in-flight operation is discarded and no result is produced.
//  FSM:
//   - IDLE  -> SHIFT on in_valid_i&in_ready_o.
//       * Load data reg=Data_i, Shift=0, lvl=LEVELS-1.
//       * If Data_i==0, go to DONE instead with Data_o=0, Shift_o=0, Zero_o=1.
//   - SHIFT, one level per cycle, k=lvl:
//       * If top 2^k bits of data reg are all 0 (and 2^k <= SWR-1): data <<= 2^k, Shift += 2^k.
//       * Otherwise data and Shift are unchanged.
//       * If lvl==0 go to DONE, else lvl-1.
//   - DONE  -> IDLE on out_ready_i.
//       * Outputs hold stable while out_ready_i=0.
//  Latency:
//   - Nonzero input: out_valid_o rises LEVELS+1 edges after the accept edge (1 load + LEVELS shift edges).
//   - Zero input: out_valid_o rises 1 edge after the accept edge.
//  Throughput: one operation at a time; in_ready_o=0 in SHIFT and DONE.
//   - in_valid_i outside IDLE is ignored; the upstream holds the data.
//  Data_o/Shift_o/Zero_o: registered; they change only on load/shift edges and hold through DONE.
//   - Zero_o clears on the next accept.
//  Arithmetic:
//   - Shift_o never exceeds SWR-1.
//   - No bits are shifted out except leading zeros; set bits are never lost.
//  Simultaneous events:
//   - out_ready_i in DONE together with in_valid_i: no same-cycle accept.
//   - The new input is accepted in the following IDLE cycle.
// TESTING (SWR=26)
//  1. Data_i=26'h2000000 -> Data_o=26'h2000000, Shift_o=0, Zero_o=0; out_valid_o 6 edges after accept.
//  2. Data_i=26'h0000001 -> Data_o=26'h2000000, Shift_o=25, Zero_o=0.
//  3. Data_i=26'h0001234 -> Data_o=26'h2468000, Shift_o=13.
//  4. Data_i=0 -> Zero_o=1, Data_o=0, Shift_o=0; out_valid_o 1 edge after accept.
//  5. Hold out_ready_i=0 for 10 cycles in DONE while pulsing in_valid_i.
//     -> Outputs stable, in_ready_o=0, no extra accepts; result taken on release.
//  6. Assert rst 2 cycles into SHIFT (case 2 input).
//     -> Immediately IDLE, out_valid_o=0, outputs 0.
//     -> Next input 26'h0000100 yields Shift_o=17, Data_o=26'h2000000.

Source files
------------

// File: rtl/left_norm_shifter_seq.sv
// rtl/left_norm_shifter_seq.sv - iterative left-normalization shifter, one binary-search level per cycle
// Removes leading zeros largest level first; reports shift count and zero flag.

module left_norm_shifter_seq #(
  parameter  int SWR    = 26,
  localparam int LEVELS = $clog2(SWR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [SWR-1:0]    Data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [SWR-1:0]    Data_o,
  output logic [LEVELS-1:0] Shift_o,
  output logic              Zero_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [SWR-1:0]      data_q;
  logic [LEVELS-1:0]   shift_q;
  logic [LEVELS-1:0]   lvl_q;
  logic                zero_q;
  int                  step;
  logic                do_shift;

  // True when the n most significant bits of d are all zero.
  function automatic logic top_zero(input logic [SWR-1:0] d, input int n);
    logic [SWR-1:0] t;
    t = d >> (SWR - n);
    return (t == '0);
  endfunction

  always_comb begin
    state_d  = state_q;
    step     = 1 << lvl_q;
    do_shift = 1'b0;
    if (step <= SWR - 1) begin
      do_shift = top_zero(data_q, step);
    end
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = (Data_i == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (lvl_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      shift_q <= '0;
      lvl_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            data_q  <= Data_i;
            shift_q <= '0;
            zero_q  <= (Data_i == '0);
            lvl_q   <= LEVELS'(LEVELS - 1);
          end
        end
        SHIFT: begin
          if (do_shift) begin
            data_q  <= data_q << step;
            shift_q <= shift_q + LEVELS'(step);
          end
          if (lvl_q != '0) begin
            lvl_q <= lvl_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign Data_o      = data_q;
  assign Shift_o     = shift_q;
  assign Zero_o      = zero_q;

endmodule
